// File: rtl/tetris_input_ctrl.sv
// Turns PS/2 set-2 key events into Tetris actions, with delayed auto-shift for LEFT/RIGHT/DOWN.
// Actions are buffered in a small FIFO with a sticky overflow flag.
module tetris_input_ctrl #(
    parameter int unsigned DAS_CYCLES = 10_000_000,
    parameter int unsigned ARR_CYCLES = 3_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] current_scan_code,
    input  logic       current_make_break,
    output logic       action_valid,
    output logic [2:0] action_code,
    input  logic       action_ready,
    output logic       overflow
);

    localparam int unsigned MaxCyc = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] DasMax = CntW'(DAS_CYCLES - 1);
    localparam logic [CntW-1:0] ArrMax = CntW'(ARR_CYCLES - 1);
    localparam logic [2:0] ActLeft  = 3'd0;
    localparam logic [2:0] ActRight = 3'd1;
    localparam logic [2:0] ActDown  = 3'd2;

    typedef enum logic [1:0] {StIdle, StDas, StRepeat} rep_st_e;

    typedef struct packed {
        rep_st_e         st;
        logic [CntW-1:0] cnt;
        logic            req;
    } rep_t;

    // Free-running step of a repeater when no key event overrides it.
    function automatic rep_t rep_step(input rep_st_e st, input logic [CntW-1:0] cnt);
        rep_t r;
        r.st  = st;
        r.cnt = cnt;
        r.req = 1'b0;
        case (st)
            StDas: begin
                if (cnt == DasMax) begin
                    r.req = 1'b1;
                    r.cnt = '0;
                    r.st  = StRepeat;
                end else begin
                    r.cnt = cnt + 1'b1;
                end
            end
            StRepeat: begin
                if (cnt == ArrMax) begin
                    r.req = 1'b1;
                    r.cnt = '0;
                end else begin
                    r.cnt = cnt + 1'b1;
                end
            end
            default: r.cnt = '0;
        endcase
        return r;
    endfunction

    logic [8:0]      key_q, key_prev_q;
    logic            left_held_q, left_held_d, right_held_q, right_held_d;
    logic            down_held_q, down_held_d;
    rep_st_e         h_st_q, h_st_d, v_st_q, v_st_d;
    logic [CntW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic            h_dir_q, h_dir_d, h_pcode_q, h_pcode_d;
    logic            h_pend_q, h_pend_d, v_pend_q, v_pend_d;
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   cnt_q, cnt_d;
    logic            overflow_q, overflow_d;

    logic       key_event, is_make, mapped, key_wr;
    logic [2:0] act;
    logic       mk_left, mk_right, mk_down, brk_left, brk_right, brk_down;
    rep_t       h_step, v_step;
    logic       h_req, v_req, h_drop, v_drop, h_want, v_want, h_grant, v_grant;
    logic       wr_req, push, pop, full;
    logic [2:0] wr_code;

    assign action_valid = (cnt_q != '0);
    assign action_code  = action_valid ? mem_q[rd_ptr_q] : 3'd0;
    assign overflow     = overflow_q;
    assign full         = (cnt_q == (PtrW+1)'(FIFO_DEPTH));
    assign pop          = action_valid & action_ready;

    always_comb begin
        key_event = (key_q != key_prev_q);
        is_make   = key_q[0];
        mapped    = 1'b1;
        act       = 3'd0;
        case (key_q[8:1])
            8'h6B:   act = 3'd0;
            8'h74:   act = 3'd1;
            8'h72:   act = 3'd2;
            8'h75:   act = 3'd3;
            8'h29:   act = 3'd4;
            8'h12:   act = 3'd5;
            8'h76:   act = 3'd6;
            default: mapped = 1'b0;
        endcase
        key_wr    = key_event & mapped & is_make;
        mk_left   = key_wr & (act == ActLeft);
        mk_right  = key_wr & (act == ActRight);
        mk_down   = key_wr & (act == ActDown);
        brk_left  = key_event & mapped & !is_make & (act == ActLeft);
        brk_right = key_event & mapped & !is_make & (act == ActRight);
        brk_down  = key_event & mapped & !is_make & (act == ActDown);
    end

    always_comb begin
        left_held_d  = (left_held_q | mk_left) & !brk_left;
        right_held_d = (right_held_q | mk_right) & !brk_right;
        down_held_d  = (down_held_q | mk_down) & !brk_down;

        h_step  = rep_step(h_st_q, h_cnt_q);
        h_st_d  = h_step.st;
        h_cnt_d = h_step.cnt;
        h_req   = h_step.req;
        h_dir_d = h_dir_q;
        h_drop  = 1'b0;
        if (mk_left || mk_right) begin
            h_dir_d = mk_right;
            h_cnt_d = '0;
            h_st_d  = StDas;
            h_req   = 1'b0;
        end else if ((brk_left && !h_dir_q) || (brk_right && h_dir_q)) begin
            h_req   = 1'b0;
            h_cnt_d = '0;
            // Releasing the active direction hands over to the other one if it is still down.
            if (h_dir_q ? left_held_q : right_held_q) begin
                h_dir_d = !h_dir_q;
                h_st_d  = StDas;
            end else begin
                h_st_d = StIdle;
                h_drop = 1'b1;
            end
        end

        v_step  = rep_step(v_st_q, v_cnt_q);
        v_st_d  = v_step.st;
        v_cnt_d = v_step.cnt;
        v_req   = v_step.req;
        v_drop  = 1'b0;
        if (mk_down) begin
            v_cnt_d = '0;
            v_st_d  = StDas;
            v_req   = 1'b0;
        end else if (brk_down) begin
            v_cnt_d = '0;
            v_st_d  = StIdle;
            v_req   = 1'b0;
            v_drop  = 1'b1;
        end

        h_want  = h_pend_q | h_req;
        v_want  = v_pend_q | v_req;
        wr_req  = 1'b0;
        wr_code = 3'd0;
        h_grant = 1'b0;
        v_grant = 1'b0;
        if (key_wr) begin
            wr_req  = 1'b1;
            wr_code = act;
        end else if (h_want) begin
            wr_req  = 1'b1;
            h_grant = 1'b1;
            wr_code = (h_pend_q ? h_pcode_q : h_dir_q) ? ActRight : ActLeft;
        end else if (v_want) begin
            wr_req  = 1'b1;
            v_grant = 1'b1;
            wr_code = ActDown;
        end
        h_pend_d  = h_want & !h_grant & !h_drop;
        h_pcode_d = h_pend_q ? h_pcode_q : h_dir_q;
        v_pend_d  = v_want & !v_grant & !v_drop;

        push       = wr_req & (!full | pop);
        overflow_d = overflow_q | (wr_req & full & !pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d      = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q        <= '0;
            key_prev_q   <= '0;
            left_held_q  <= 1'b0;
            right_held_q <= 1'b0;
            down_held_q  <= 1'b0;
            h_st_q       <= StIdle;
            v_st_q       <= StIdle;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            h_dir_q      <= 1'b0;
            h_pcode_q    <= 1'b0;
            h_pend_q     <= 1'b0;
            v_pend_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            key_q        <= {current_scan_code, current_make_break};
            key_prev_q   <= key_q;
            left_held_q  <= left_held_d;
            right_held_q <= right_held_d;
            down_held_q  <= down_held_d;
            h_st_q       <= h_st_d;
            v_st_q       <= v_st_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            h_dir_q      <= h_dir_d;
            h_pcode_q    <= h_pcode_d;
            h_pend_q     <= h_pend_d;
            v_pend_q     <= v_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule
